// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants, result type and configuration check for pipelined_adder
// Purpose: default geometry, the {sum, carry, ovf} result record, and the
//          WIDTH/STAGES legality check used at elaboration.
// Ports:   none (package).
package adder_pkg;

    localparam int DEFAULT_WIDTH  = 16;
    localparam int DEFAULT_STAGES = 4;

    typedef struct packed {
        logic [DEFAULT_WIDTH-1:0] sum;
        logic                     carry;
        logic                     ovf;
    } result_t;

    // Each stage must own an equal, non-empty slice of the operands.
    function automatic bit cfg_ok(int width, int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/adder_stage.sv
// rtl/adder_stage.sv - one CHUNK-bit slice of the pipelined adder with its valid/ready register slice
// Purpose: adds operand bits [IDX*CHUNK +: CHUNK] plus the incoming carry,
//          merges the partial sum into the running sum, and carries the
//          operands forward for later stages.
// Ports:   clk, rst_n           clock, synchronous active-low reset
//          up_valid/up_ready    handshake with the previous stage (or input)
//          up_a, up_b           operands (B already inverted for subtract)
//          up_sum, up_carry     running sum and carry from the previous stage
//          valid/down_ready     handshake with the next stage (or output)
//          a, b, sum, carry     registered state handed to the next stage
//          ovf                  signed overflow; only meaningful in the last stage
module adder_stage #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_a,
    input  logic [WIDTH-1:0] up_b,
    input  logic [WIDTH-1:0] up_sum,
    input  logic             up_carry,
    output logic             valid,
    input  logic             down_ready,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             ovf
);

    localparam int LO = IDX * CHUNK;

    logic [CHUNK:0]   part;
    logic [WIDTH-1:0] sum_next;
    logic             top_cin;

    always_comb begin
        part     = {1'b0, up_a[LO +: CHUNK]} + {1'b0, up_b[LO +: CHUNK]}
                 + {{CHUNK{1'b0}}, up_carry};
        sum_next = up_sum;
        sum_next[LO +: CHUNK] = part[CHUNK-1:0];
        // Carry into the slice's top bit, recovered from that bit's sum.
        top_cin  = up_a[LO+CHUNK-1] ^ up_b[LO+CHUNK-1] ^ part[CHUNK-1];
    end

    // A bubble here lets the upstream stage advance even while downstream stalls.
    assign up_ready = !valid || down_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            a     <= '0;
            b     <= '0;
            sum   <= '0;
            carry <= 1'b0;
            ovf   <= 1'b0;
        end else if (up_ready) begin
            valid <= up_valid;
            // Data only loads on a real transfer so outputs hold across gaps.
            if (up_valid) begin
                a     <= up_a;
                b     <= up_b;
                sum   <= sum_next;
                carry <= part[CHUNK];
                ovf   <= part[CHUNK] ^ top_cin;
            end
        end
    end

endmodule

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - WIDTH-bit adder split into STAGES carry-chained pipeline stages
// Purpose: one operand pair per cycle in, {sum, carry, ovf} out STAGES cycles
//          later, with full valid/ready back-pressure.
// Ports:   clk, rst_n                      clock, synchronous active-low reset
//          in_valid/in_ready               operand handshake
//          in_a, in_b, in_cin              operands and carry-in
//          in_sub (ADDER_SUB_EN only)      1 = compute A-B, in_cin ignored
//          out_valid/out_ready             result handshake
//          out_sum, out_carry, out_ovf     result, carry-out, signed overflow
// Macro:   ADDER_SUB_EN enables the in_sub port and subtraction.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef ADDER_SUB_EN
    input  logic             in_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_ovf
);

    localparam int CHUNK = WIDTH / STAGES;

    if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH must be a non-zero multiple of STAGES");
    end

    // Index 0 is the input side; index k+1 is the output of stage k.
    logic             valid_s [0:STAGES];
    logic             ready_s [0:STAGES];
    logic [WIDTH-1:0] a_s     [0:STAGES];
    logic [WIDTH-1:0] b_s     [0:STAGES];
    logic [WIDTH-1:0] sum_s   [0:STAGES];
    logic             carry_s [0:STAGES];
    logic             ovf_s   [0:STAGES];

    // Subtraction is A + ~B + 1: invert B once at entry and force carry_0.
`ifdef ADDER_SUB_EN
    assign b_s[0]     = in_sub ? ~in_b : in_b;
    assign carry_s[0] = in_sub ? 1'b1  : in_cin;
`else
    assign b_s[0]     = in_b;
    assign carry_s[0] = in_cin;
`endif

    assign valid_s[0]      = in_valid;
    assign a_s[0]          = in_a;
    assign sum_s[0]        = '0;
    assign ovf_s[0]        = 1'b0;
    assign ready_s[STAGES] = out_ready;
    assign in_ready        = ready_s[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        adder_stage #(
            .WIDTH (WIDTH),
            .CHUNK (CHUNK),
            .IDX   (k)
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .up_valid   (valid_s[k]),
            .up_ready   (ready_s[k]),
            .up_a       (a_s[k]),
            .up_b       (b_s[k]),
            .up_sum     (sum_s[k]),
            .up_carry   (carry_s[k]),
            .valid      (valid_s[k+1]),
            .down_ready (ready_s[k+1]),
            .a          (a_s[k+1]),
            .b          (b_s[k+1]),
            .sum        (sum_s[k+1]),
            .carry      (carry_s[k+1]),
            .ovf        (ovf_s[k+1])
        );
    end

    assign out_valid = valid_s[STAGES];
    assign out_sum   = sum_s[STAGES];
    assign out_carry = carry_s[STAGES];
    assign out_ovf   = ovf_s[STAGES];

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - self-checking bench for pipelined_adder (WIDTH=16, STAGES=4)
module tb_pipelined_adder;
    import adder_pkg::*;

    localparam int W = DEFAULT_WIDTH;
    localparam int S = DEFAULT_STAGES;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_cin = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_ready, out_valid, out_carry, out_ovf;
    logic [W-1:0] out_sum;
`ifdef ADDER_SUB_EN
    logic         in_sub = 1'b0;
`endif

    pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
`ifdef ADDER_SUB_EN
        .in_sub    (in_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    int      checks = 0;
    int      failures = 0;
    int      cyc = 0;
    int      emitted = 0;
    result_t exp_q[$];
    int      acc_q[$];
    result_t last;
    result_t held;
    bit      hold_pend = 1'b0;
    bit      lat_chk = 1'b0;

    function automatic logic cur_sub();
`ifdef ADDER_SUB_EN
        return in_sub;
`else
        return 1'b0;
`endif
    endfunction

    // Reference: plain wide arithmetic and the sign rule for overflow.
    function automatic result_t model(logic [W-1:0] a, logic [W-1:0] b, logic cin, logic sub);
        logic [W:0]   full;
        logic [W-1:0] bb;
        logic         c;
        result_t      r;
        bb = sub ? ~b : b;
        c  = sub ? 1'b1 : cin;
        full    = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c};
        r.sum   = full[W-1:0];
        r.carry = full[W];
        r.ovf   = (a[W-1] == bb[W-1]) && (r.sum[W-1] != a[W-1]);
        return r;
    endfunction

    task automatic tick();
        result_t got;
        result_t e;
        int      ac;
        @(negedge clk);
        got = '{sum: out_sum, carry: out_carry, ovf: out_ovf};
        if (hold_pend && out_valid) begin
            checks++;
            assert (got === held) else begin
                failures++;
                $error("FAIL stall_hold observed=%h expected=%h", got, held);
            end
        end
        hold_pend = out_valid && !out_ready;
        held = got;
        if (out_valid && out_ready) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                failures++;
                $error("FAIL unexpected_output observed=%h expected=none", got);
            end
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                ac = acc_q.pop_front();
                checks++;
                assert (got === e) else begin
                    failures++;
                    $error("FAIL result observed=%h expected=%h", got, e);
                end
                if (lat_chk) begin
                    checks++;
                    assert ((cyc - ac) === S) else begin
                        failures++;
                        $error("FAIL latency observed=%0d expected=%0d", cyc - ac, S);
                    end
                end
            end
            last = got;
            emitted++;
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(model(in_a, in_b, in_cin, cur_sub()));
            acc_q.push_back(cyc);
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() > 0; i++) tick();
        checks++;
        assert (exp_q.size() === 0) else begin
            failures++;
            $error("FAIL drain_timeout observed=%0d expected=0", exp_q.size());
        end
    endtask

    task automatic send(logic [W-1:0] a, logic [W-1:0] b, logic cin);
        in_a = a;
        in_b = b;
        in_cin = cin;
        in_valid = 1'b1;
        for (int i = 0; i < 60 && !in_ready; i++) tick();
        tick();
        in_valid = 1'b0;
    endtask

    task automatic check_last(result_t e, string tag);
        checks++;
        assert (last === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, last, e);
        end
    endtask

    int n_acc;
    int em0;

    initial begin
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        checks++;
        assert ({out_valid, out_sum, out_carry, out_ovf, in_ready} === {1'b0, 16'h0, 1'b0, 1'b0, 1'b1}) else begin
            failures++;
            $error("FAIL reset_state observed=%b/%h/%b/%b/%b expected=0/0000/0/0/1",
                   out_valid, out_sum, out_carry, out_ovf, in_ready);
        end

        // Directed: single op, full carry ripple, signed overflow.
        lat_chk = 1'b1;
        send(16'h00FF, 16'h0001, 1'b0);
        drain();
        check_last('{sum: 16'h0100, carry: 1'b0, ovf: 1'b0}, "single_op");
        send(16'hFFFF, 16'h0001, 1'b0);
        drain();
        check_last('{sum: 16'h0000, carry: 1'b1, ovf: 1'b0}, "carry_ripple");
        send(16'h7FFF, 16'h0001, 1'b0);
        drain();
        check_last('{sum: 16'h8000, carry: 1'b0, ovf: 1'b1}, "signed_ovf");
        send(16'hFFFF, 16'hFFFF, 1'b1);
        drain();
        check_last('{sum: 16'hFFFF, carry: 1'b1, ovf: 1'b0}, "cin_max");

        // Back-to-back streaming of 20 random pairs.
        em0 = emitted;
        for (int i = 0; i < 20; i++) begin
            in_a = W'($urandom);
            in_b = W'($urandom);
            in_cin = 1'($urandom);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        drain();
        checks++;
        assert ((emitted - em0) === 20) else begin
            failures++;
            $error("FAIL stream_count observed=%0d expected=20", emitted - em0);
        end
        lat_chk = 1'b0;

        // Back-pressure: consumer stalled for 10 cycles with input always offered.
        out_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 10; i++) begin
            in_a = W'($urandom);
            in_b = W'($urandom);
            in_cin = 1'($urandom);
            in_valid = 1'b1;
            if (in_ready) n_acc++;
            tick();
        end
        checks++;
        assert (n_acc === S) else begin
            failures++;
            $error("FAIL bp_accepts observed=%0d expected=%0d", n_acc, S);
        end
        checks++;
        assert (in_ready === 1'b0) else begin
            failures++;
            $error("FAIL bp_in_ready observed=%b expected=0", in_ready);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        // Random valid/ready traffic.
        for (int i = 0; i < 60; i++) begin
            in_a = W'($urandom);
            in_b = W'($urandom);
            in_cin = 1'($urandom);
            in_valid = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset with three operations in flight.
        for (int i = 0; i < 3; i++) begin
            in_a = W'($urandom);
            in_b = W'($urandom);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        exp_q.delete();
        acc_q.delete();
        hold_pend = 1'b0;
        rst_n = 1'b1;
        checks++;
        assert (out_valid === 1'b0) else begin
            failures++;
            $error("FAIL reset_flush observed=%b expected=0", out_valid);
        end
        em0 = emitted;
        repeat (10) tick();
        checks++;
        assert (emitted === em0) else begin
            failures++;
            $error("FAIL stale_after_reset observed=%0d expected=%0d", emitted, em0);
        end

`ifdef ADDER_SUB_EN
        in_sub = 1'b1;
        send(16'h0005, 16'h0007, 1'b0);
        drain();
        check_last('{sum: 16'hFFFE, carry: 1'b0, ovf: 1'b0}, "sub_borrow");
        send(16'h8000, 16'h0001, 1'b1);
        drain();
        check_last('{sum: 16'h7FFF, carry: 1'b1, ovf: 1'b1}, "sub_ovf");
        in_sub = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
